enable_strobe_gen: RTL and testbench
====================================

Name: enable_strobe_gen

Overview:
- Programmable enable-strobe generator that drives the `enable` input of the WIDTH-parameterised D flip-flop in the basic_logic pattern set.
- Emits single-cycle enable strobes at a programmable period, either continuously or as a counted burst.
- Exposes busy, done and strobe count so a controller can sequence data capture.
- All outputs are registered; single clock domain.

Parameters:
CNT_W, 8, width of the period, burst-length and strobe-count fields.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  begin a run; honoured in IDLE only
stop  input  1  abort the current run; honoured in RUN only
period  input  CNT_W  strobe spacing in cycles; 0 treated as 1; latched on start
burst_len  input  CNT_W  strobes per run; 0 = continuous until stop; latched on start
enable  output  1  single-cycle strobe to the downstream flop's enable
busy  output  1  high while in RUN
done  output  1  single-cycle pulse after the last strobe of a finite burst
strobe_cnt  output  CNT_W  strobes emitted in the current or last run; saturates at all-ones

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-run):
  - state = IDLE.
  - enable, busy, done = 0; strobe_cnt = 0.
  - Internal phase counter, latched period and latched burst_len = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 → RUN at E0.
  - At E0: Pm = max(period,1) latched; burst_len latched; strobe_cnt cleared to 0; phase = 0.
  - stop in IDLE is ignored.
- RUN:
  - busy=1.
  - enable is high during the cycle after E0, so the downstream flop captures at E1.
  - Subsequent strobes every Pm cycles: enable high in cycles E0+1, E0+1+Pm, E0+1+2Pm, ...
  - Pm=1 gives enable high every RUN cycle.
  - Each strobe increments strobe_cnt, saturating at 2^CNT_W-1.
- Burst completion (burst_len≠0):
  - The edge that ends the cycle carrying strobe number burst_len moves the FSM to DONE.
  - busy drops and done=1 for exactly one cycle; no further enable.
- Continuous mode (burst_len=0): RUN persists until stop; strobe_cnt saturates but strobes continue.
- stop in RUN, sampled at edge Es:
  - → IDLE at Es; busy=0 and enable=0 from the cycle after Es.
  - done is not asserted; strobe_cnt holds its final value.
  - If Es lands on a strobe edge, that strobe is suppressed.
- Priority in RUN: stop > burst completion.
- start while in RUN is ignored.
- period and burst_len changes during RUN are ignored; latched values govern the run.
- DONE:
  - Always lasts one cycle, then → IDLE.
  - start or stop during DONE is ignored.
  - strobe_cnt holds its value.
- enable is never high outside RUN and never high for 2 consecutive cycles unless Pm=1.
- Phase counter wraps from Pm-1 to 0, with no off-by-one at the wrap.
- Maximum period 2^CNT_W-1 is exact.

Test Plan:
- Reset mid-run: RUN with P=4, deassert rst_n asynchronously between edges → enable/busy/done/strobe_cnt read 0 before the next edge; stays IDLE after release until start.
- Continuous, P=3, burst_len=0:
  - Stimulus: start at edge 0.
  - Response: enable high in cycles 1,4,7,10; busy=1 throughout; strobe_cnt=4 after cycle 10.
  - Then stop at edge 11: no enable from cycle 12; busy=0; done never asserted.
- Burst, P=2, burst_len=3:
  - Stimulus: start at edge 0.
  - Response: enable in cycles 1,3,5; done high only in cycle 6; busy low from cycle 6; strobe_cnt=3.
  - With the D flop attached (WIDTH=8, d=cycle index), q captures 1,3,5.
- P=0 and P=1, burst_len=4: enable high in cycles 1–4 consecutively; done in cycle 5.
- Ignored inputs:
  - start again in cycle 2 of a P=5 run, plus period changed to 1 mid-run → spacing stays 5, strobe_cnt not cleared.
  - stop and start asserted together in IDLE → RUN entered.
  - stop and start asserted together in RUN → IDLE.
- Saturation, CNT_W=4, P=1, continuous:
  - Run 20 cycles → strobe_cnt sticks at 15 while enable keeps pulsing.
  - P=15 → enable exactly 15 cycles apart.

Source files
------------

// File: rtl/enable_strobe_gen_if.sv
// Control/status bundle for enable_strobe_gen: run requests and the latched-on-start
// configuration in, registered strobe and run status out.
interface enable_strobe_gen_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] burst_len;
  logic             enable;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] strobe_cnt;

  modport master (
    output start, stop, period, burst_len,
    input  enable, busy, done, strobe_cnt
  );

  modport slave (
    input  start, stop, period, burst_len,
    output enable, busy, done, strobe_cnt
  );
endinterface

// File: rtl/enable_strobe_gen.sv
// Programmable single-cycle enable strobe generator: continuous or counted bursts at a
// latched period, with busy/done status and a saturating strobe count.
module enable_strobe_gen #(
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  enable_strobe_gen_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] phase_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] burst_q;
  logic [CNT_W-1:0] cnt_q;
  logic             enable_q;
  logic             busy_q;
  logic             done_q;

  logic [CNT_W-1:0] period_in;
  logic [CNT_W-1:0] phase_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             burst_end;

  always_comb begin
    period_in = (bus.period == '0) ? CNT_W'(1) : bus.period;
    phase_nxt = (phase_q == period_q - CNT_W'(1)) ? '0 : phase_q + CNT_W'(1);
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    // Strobe in flight is the burst_len-th one; burst_q - 1 never reaches the saturated count.
    burst_end = enable_q && (burst_q != '0) && (cnt_q == burst_q - CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      phase_q  <= '0;
      period_q <= '0;
      burst_q  <= '0;
      cnt_q    <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q  <= StRun;
            period_q <= period_in;
            burst_q  <= bus.burst_len;
            cnt_q    <= '0;
            phase_q  <= '0;
            enable_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        StRun: begin
          // A strobe is counted at the edge that closes its cycle, even if stop lands there.
          if (enable_q) cnt_q <= cnt_inc;
          if (bus.stop) begin
            state_q  <= StIdle;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
          end else if (burst_end) begin
            state_q  <= StDone;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            phase_q  <= phase_nxt;
            enable_q <= (phase_nxt == '0);
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q  <= StIdle;
          enable_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.enable     = enable_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.strobe_cnt = cnt_q;

endmodule

// File: tb/tb_enable_strobe_gen.sv
// Scoreboard bench for enable_strobe_gen: per-cycle expectations queued at launch, popped
// and compared each cycle; an 8-bit and a 4-bit instance share the stimulus.
module tb_enable_strobe_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8, start4, stop_s;
  logic [7:0] per_s, bl_s;

  enable_strobe_gen_if #(.CNT_W(8)) bus8 ();
  enable_strobe_gen_if #(.CNT_W(4)) bus4 ();

  assign bus8.start     = start8;
  assign bus8.stop      = stop_s;
  assign bus8.period    = per_s;
  assign bus8.burst_len = bl_s;
  assign bus4.start     = start4;
  assign bus4.stop      = stop_s;
  assign bus4.period    = per_s[3:0];
  assign bus4.burst_len = bl_s[3:0];

  enable_strobe_gen #(.CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  enable_strobe_gen #(.CNT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct {
    bit en;
    bit busy;
    bit done;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   cap_seen[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   d_val = 0;
  bit   cap_on = 1'b0;
  bit   cur_sel = 1'b0;

  // Downstream D flop model: captures the cycle index whenever the strobe is high.
  always @(posedge clk)
    if (cap_on && (cur_sel ? bus4.enable : bus8.enable)) cap_seen.push_back(d_val);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic check_outs(input string tag, input bit sel, input exp_t e);
    logic        o_en, o_busy, o_done;
    logic [31:0] o_cnt;
    o_en   = sel ? bus4.enable : bus8.enable;
    o_busy = sel ? bus4.busy   : bus8.busy;
    o_done = sel ? bus4.done   : bus8.done;
    o_cnt  = sel ? 32'(bus4.strobe_cnt) : 32'(bus8.strobe_cnt);
    check({tag, " en"},   32'(o_en),   32'(e.en));
    check({tag, " busy"}, 32'(o_busy), 32'(e.busy));
    check({tag, " done"}, 32'(o_done), 32'(e.done));
    check({tag, " cnt"},  o_cnt,       32'(e.cnt));
  endtask

  // es: cycle during which stop (with start) is held; ks: cycle during which start alone is held.
  task automatic run_case(input string name, input bit sel, input int per, input int bl,
                          input int ncyc, input int es, input int ks);
    exp_t e;
    int   exp_cap[$];
    int   pm, cmax, cnt, nstr;
    bit   run, dn;
    pm = (per == 0) ? 1 : per;
    cmax = sel ? 15 : 255;
    run = 1'b1; dn = 1'b0; cnt = 0; nstr = 0;
    for (int k = 1; k <= ncyc; k++) begin
      e.en = run && ((k - 1) % pm == 0);
      e.busy = run;
      e.done = dn;
      e.cnt = cnt;
      exp_q.push_back(e);
      if (e.en) begin
        exp_cap.push_back(k);
        nstr++;
        if (cnt < cmax) cnt++;
      end
      dn = 1'b0;
      if (run) begin
        if (k == es) run = 1'b0;
        else if (e.en && bl != 0 && nstr == bl) begin
          run = 1'b0;
          dn = 1'b1;
        end
      end
    end

    cur_sel = sel;
    cap_seen.delete();
    cap_on = 1'b1;
    per_s = 8'(per);
    bl_s = 8'(bl);
    stop_s = 1'b1;  // stop alongside start in IDLE must not block the launch
    if (sel) start4 = 1'b1; else start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0; start8 = 1'b0; stop_s = 1'b0;
    per_s = 8'd1; bl_s = 8'd0;  // mid-run changes must be ignored
    for (int k = 1; k <= ncyc; k++) begin
      d_val = k;
      e = exp_q.pop_front();
      check_outs($sformatf("%s c%0d", name, k), sel, e);
      stop_s = (k == es);
      if (sel) start4 = (k == es) || (k == ks); else start8 = (k == es) || (k == ks);
      @(posedge clk);
      @(negedge clk);
    end
    stop_s = 1'b0; start4 = 1'b0; start8 = 1'b0;
    cap_on = 1'b0;
    check({name, " ncap"}, 32'(cap_seen.size()), 32'(exp_cap.size()));
    for (int i = 0; i < exp_cap.size() && i < cap_seen.size(); i++)
      check($sformatf("%s q%0d", name, i), 32'(cap_seen[i]), 32'(exp_cap[i]));
    repeat (2) @(negedge clk);
    check({name, " idle busy"}, 32'(sel ? bus4.busy : bus8.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    start8 = 1'b0; start4 = 1'b0; stop_s = 1'b0; per_s = '0; bl_s = '0;
    repeat (2) @(negedge clk);
    check("rst en",     32'(bus8.enable), 32'd0);
    check("rst busy",   32'(bus8.busy),   32'd0);
    check("rst done",   32'(bus8.done),   32'd0);
    check("rst cnt",    32'(bus8.strobe_cnt), 32'd0);
    check("rst4 cnt",   32'(bus4.strobe_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset in cycle 5 of a P=4 run, while a strobe is high.
    per_s = 8'd4; bl_s = 8'd0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-rst en",  32'(bus8.enable), 32'd1);
    check("pre-rst cnt", 32'(bus8.strobe_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid-rst en",   32'(bus8.enable), 32'd0);
    check("mid-rst busy", 32'(bus8.busy),   32'd0);
    check("mid-rst done", 32'(bus8.done),   32'd0);
    check("mid-rst cnt",  32'(bus8.strobe_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post-rst busy", 32'(bus8.busy),   32'd0);
    check("post-rst en",   32'(bus8.enable), 32'd0);
    check("post-rst cnt",  32'(bus8.strobe_cnt), 32'd0);

    run_case("cont p3",   1'b0, 3,   0, 12,  11, -1);
    run_case("burst p2",  1'b0, 2,   3, 8,   -1, 6);
    run_case("p0 b4",     1'b0, 0,   4, 7,   -1, -1);
    run_case("p1 b4",     1'b0, 1,   4, 7,   -1, -1);
    run_case("p5 restart",1'b0, 5,   3, 13,  -1, 2);
    run_case("b1",        1'b0, 6,   1, 4,   -1, -1);
    run_case("p255",      1'b0, 255, 2, 258, -1, -1);
    run_case("sat p1",    1'b1, 1,   0, 21,  20, -1);
    run_case("p15",       1'b1, 15,  0, 33,  32, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
